// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: synchronises and deglitches the pins,
// deserialises 11-bit frames and folds E0/F0 prefixes into flags.
module ps2_scancode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clkps2,
  input  logic       dataps2,
  output logic [7:0] scancode,
  output logic       extended,
  output logic       released,
  output logic       code_valid,
  output logic       frame_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic [1:0]            clk_sync;
  logic [1:0]            dat_sync;
  logic [FILTER_LEN-1:0] flt;
  logic                  clk_f;
  logic                  clk_lvl;
  logic                  fall_tick;
  logic                  dat;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic          pend_ext;
  logic          pend_rel;
  logic [TW-1:0] tcnt;

  assign dat = dat_sync[1];

  // The filtered level only moves once every tap agrees; otherwise it holds.
  always_comb begin
    clk_lvl = clk_f;
    if (flt == '0) clk_lvl = 1'b0;
    else if (&flt) clk_lvl = 1'b1;
  end

  assign fall_tick = clk_f & ~clk_lvl;

  // Two-flop synchronisers on both raw pins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], clkps2};
      dat_sync <= {dat_sync[0], dataps2};
    end
  end

  // Glitch filter shift register and the held filtered clock level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      flt   <= '1;
      clk_f <= 1'b1;
    end else begin
      flt   <= {flt[FILTER_LEN-2:0], clk_sync[1]};
      clk_f <= clk_lvl;
    end
  end

  // Frame FSM, prefix folding, timeout and registered strobes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      shreg       <= 8'h00;
      par_bit     <= 1'b0;
      pend_ext    <= 1'b0;
      pend_rel    <= 1'b0;
      tcnt        <= '0;
      scancode    <= 8'h00;
      extended    <= 1'b0;
      released    <= 1'b0;
      code_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      code_valid  <= 1'b0;
      frame_error <= 1'b0;

      if (state == IDLE || fall_tick) tcnt <= '0;
      else if (tcnt != T_LAST) tcnt <= tcnt + 1'b1;

      if (state != IDLE && !fall_tick && tcnt == T_LAST) begin
        state       <= IDLE;
        frame_error <= 1'b1;
        pend_ext    <= 1'b0;
        pend_rel    <= 1'b0;
      end else if (fall_tick) begin
        unique case (state)
          IDLE: begin
            if (!dat) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end else begin
              frame_error <= 1'b1;
              pend_ext    <= 1'b0;
              pend_rel    <= 1'b0;
            end
          end
          DATA: begin
            shreg   <= {dat, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= dat;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (dat && (^{shreg, par_bit})) begin
              if (shreg == 8'hE0) begin
                pend_ext <= 1'b1;
              end else if (shreg == 8'hF0) begin
                pend_rel <= 1'b1;
              end else begin
                scancode   <= shreg;
                extended   <= pend_ext;
                released   <= pend_rel;
                code_valid <= 1'b1;
                pend_ext   <= 1'b0;
                pend_rel   <= 1'b0;
              end
            end else begin
              frame_error <= 1'b1;
              pend_ext    <= 1'b0;
              pend_rel    <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: doc/ps2_scancode_rx.md
Name: ps2_scancode_rx

Overview:
PS/2 device-to-host receiver that feeds the Jupiter Ace keyboard matrix translator. It samples the raw clkps2/dataps2 pins in the 25 MHz pixel-clock domain, deglitches the PS/2 clock and deserialises 11-bit frames. It checks start, odd parity and stop bits, and folds the E0/F0 prefix bytes into flags. It presents one strobed, decoded scancode per key event to the matrix stage.

Parameters:
FILTER_LEN, 8, number of consecutive identical synchronised samples required to change the filtered PS/2 clock level
TIMEOUT_CYCLES, 50000, clk cycles without a filtered falling edge before a partial frame is abandoned (2 ms at 25 MHz)

Ports:
clk  input  1  system clock (25 MHz pixel clock)
reset  input  1  synchronous, active-low reset
clkps2  input  1  raw PS/2 clock pin (asynchronous)
dataps2  input  1  raw PS/2 data pin (asynchronous)
scancode  output  8  last decoded non-prefix scancode byte
extended  output  1  scancode was preceded by E0 (qualified by code_valid)
released  output  1  scancode was preceded by F0, i.e. break code (qualified by code_valid)
code_valid  output  1  one-cycle strobe: scancode/extended/released are new
frame_error  output  1  one-cycle strobe: bad start/parity/stop bit, or timeout

Behaviour:
- Reset (reset=0 at a clk edge):
  - scancode=8'h00; extended, released, code_valid and frame_error all 0.
  - FSM to IDLE; pending prefix flags cleared; filter and synchronisers loaded with 1s; timeout counter cleared.
  - Reset mid-frame discards the partial frame with no strobe.
- Synchronisation: two flops on each pin. Filter: FILTER_LEN-deep shift register of the synchronised clock. Filtered clock goes 0 when all taps are 0 and 1 when all taps are 1; otherwise it holds.
- Sampling: a falling edge of the filtered clock (previous 1, now 0) generates fall_tick for one cycle. On fall_tick the synchronised data bit is captured. Only fall_tick advances the FSM.
- FSM:
  - IDLE: on fall_tick, if data=0 go to DATA with bit count 0. If data=1, stay in IDLE and pulse frame_error.
  - DATA: on fall_tick, shift the bit in LSB-first. After the 8th bit go to PARITY.
  - PARITY: on fall_tick, capture the parity bit and go to STOP.
  - STOP: on fall_tick, go to IDLE and evaluate the frame. The frame is good iff stop=1 and (8 data bits + parity) has an odd number of 1s.
- Good frame, data 8'hE0: set pending_ext; no strobe.
- Good frame, data 8'hF0: set pending_rel; no strobe.
- Good frame, any other byte (including E1):
  - scancode<=byte, extended<=pending_ext, released<=pending_rel, code_valid=1 for exactly one cycle.
  - Clear both pending flags in the same cycle.
  - scancode/extended/released then hold until the next code_valid.
- Bad frame: frame_error=1 for one cycle; pending flags cleared; scancode/extended/released unchanged.
- Latency: code_valid/frame_error is asserted in the clk cycle immediately after the cycle in which fall_tick of the stop bit is seen.
- Timeout: the counter runs while the FSM is not IDLE. It is cleared on every fall_tick and saturates at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES: go to IDLE, pulse frame_error, clear pending flags.
  - The counter is held at 0 while in IDLE.
- code_valid and frame_error are never asserted in the same cycle.
- Consecutive frames require no idle gap beyond the filter latency.
- Filter latency from a pin edge to fall_tick is 2+FILTER_LEN cycles. A clock glitch shorter than FILTER_LEN cycles produces no tick.
- Host-to-device transmission is out of scope; clkps2/dataps2 are input-only.

Test Plan:
- Frame 0x1C, parity 0, stop 1 (bit period 80 us) -> code_valid one cycle, scancode=0x1C, extended=0, released=0, frame_error never asserted.
- Frames F0 then 1C -> exactly one code_valid, scancode=0x1C, released=1, extended=0. A following 1C frame -> released=0.
- Frames E0, F0, 75 -> single code_valid, scancode=0x75, extended=1, released=1.
- Frame 0x1C with parity bit 1 -> frame_error one cycle, no code_valid, scancode still holds its prior value. Next good 0x24 frame -> scancode=0x24.
- 5-cycle low glitch on clkps2 while IDLE, data=0 -> no state change and no strobes. A 200-cycle low pulse -> FSM leaves IDLE.
- Stop clkps2 after 4 data bits for 60000 cycles -> frame_error at cycle 50000 after the last tick, FSM back in IDLE, next 0x1C frame decoded.
- Assert reset=0 mid-frame for one cycle, then send 0x1C -> outputs at reset values, then a clean code_valid with 0x1C.
